// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared ALU opcode encoding, instruction field bounds and issue FSM states
package alu_issue_ctrl_pkg;
  localparam int kINSN_W = 9;
  localparam int kREG_W = 3;
  localparam int kOP_MSB = 8;
  localparam int kOP_LSB = 6;
  localparam logic [3:0] kSHIFT_ZERO_CNT = 4'd8;
  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    SLL = 3'd3,
    SRL = 3'd4,
    XOR = 3'd5
  } ALUOp_mne;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    TRAP  = 2'd2
  } issue_state_t;
endpackage

// File: rtl/alu_issue_ctrl_insn_decode.sv
// insn_decode: combinational split of an instruction word into ALU op, registers, beat count and illegal flag
// ports: insn_i word in; op_o, rd_o, rs_o (0 for shifts), cnt_o beats (1..8), illegal_o for opcodes 6/7
module insn_decode import alu_issue_ctrl_pkg::*; (
  input  logic [kINSN_W-1:0] insn_i,
  output logic [2:0]         op_o,
  output logic [kREG_W-1:0]  rd_o,
  output logic [kREG_W-1:0]  rs_o,
  output logic [3:0]         cnt_o,
  output logic               illegal_o
);
  logic shift;
  assign op_o = insn_i[kOP_MSB:kOP_LSB];
  assign rd_o = insn_i[5:3];
  assign shift = (op_o == 3'(SLL)) || (op_o == 3'(SRL));
  assign rs_o = shift ? '0 : insn_i[2:0];
  // a zero shift count field encodes the maximum of eight single-bit beats
  assign cnt_o = !shift ? 4'd1 : (insn_i[2:0] == 3'd0) ? kSHIFT_ZERO_CNT : {1'b0, insn_i[2:0]};
  assign illegal_o = op_o > 3'(XOR);
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts instruction words and issues registered ALU beats, expanding shifts into 1-bit beats
// ports: in_valid/in_ready/in_insn accept side; out_valid/out_ready/out_op/out_rd/out_rs/out_last beat side;
// busy while an instruction is in flight; trap is the sticky illegal-opcode flag when ALU_ISSUE_TRAP_EN is defined
module alu_issue_ctrl import alu_issue_ctrl_pkg::*; (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [kINSN_W-1:0] in_insn,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_op,
  output logic [kREG_W-1:0]  out_rd,
  output logic [kREG_W-1:0]  out_rs,
  output logic               out_last,
  output logic               busy,
  output logic               trap
);
  logic [2:0] dec_op;
  logic [kREG_W-1:0] dec_rd, dec_rs;
  logic [3:0] dec_cnt;
  logic dec_ill;
  issue_state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [kREG_W-1:0] rd_q, rd_d, rs_q, rs_d;
  logic [3:0] rem_q, rem_d;
`ifdef ALU_ISSUE_TRAP_EN
  localparam issue_state_t kILL_STATE = TRAP;
`else
  localparam issue_state_t kILL_STATE = IDLE;
`endif
  insn_decode u_dec (
    .insn_i   (in_insn),
    .op_o     (dec_op),
    .rd_o     (dec_rd),
    .rs_o     (dec_rs),
    .cnt_o    (dec_cnt),
    .illegal_o(dec_ill)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    rd_d = rd_q;
    rs_d = rs_q;
    rem_d = rem_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = dec_ill ? kILL_STATE : ISSUE;
        if (!dec_ill) begin
          op_d = dec_op;
          rd_d = dec_rd;
          rs_d = dec_rs;
          rem_d = dec_cnt;
        end
      end
      ISSUE: if (out_ready) begin
        rem_d = rem_q - 4'd1;
        state_d = (rem_q == 4'd1) ? IDLE : ISSUE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q <= 3'(ADD);
      rd_q <= '0;
      rs_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rd_q <= rd_d;
      rs_q <= rs_d;
      rem_q <= rem_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == ISSUE;
  assign busy = state_q != IDLE;
  assign out_op = op_q;
  assign out_rd = rd_q;
  assign out_rs = rs_q;
  assign out_last = rem_q == 4'd1;
`ifdef ALU_ISSUE_TRAP_EN
  assign trap = state_q == TRAP;
`else
  assign trap = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random stimulus checked against a beat-queue reference model
module tb_alu_issue_ctrl;
  logic clk = 0;
  logic reset_n = 0;
  logic in_valid = 0;
  logic [8:0] in_insn = '0;
  logic in_ready, out_valid, out_last, busy, trap;
  logic out_ready = 1;
  logic [2:0] out_op, out_rd, out_rs;
  typedef struct {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic last;
  } beat_t;
  beat_t q[$];
  logic [2:0] m_op = 0, m_rd = 0, m_rs = 0;
  logic m_trap = 0;
  int checks = 0;
  int errors = 0;
  alu_issue_ctrl dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_insn(in_insn), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd), .out_rs(out_rs),
    .out_last(out_last), .busy(busy), .trap(trap)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic accept(input logic [8:0] w);
    int n;
    logic [2:0] opc;
    logic sh;
    opc = w[8:6];
    if (opc > 3'd5) begin
`ifdef ALU_ISSUE_TRAP_EN
      m_trap = 1;
`endif
      return;
    end
    sh = (opc == 3'd3) || (opc == 3'd4);
    n = sh ? ((w[2:0] == 0) ? 8 : int'(w[2:0])) : 1;
    m_op = opc;
    m_rd = w[5:3];
    m_rs = sh ? 3'd0 : w[2:0];
    for (int i = 0; i < n; i++) q.push_back('{opc, w[5:3], m_rs, i == n - 1});
  endtask
  task automatic tick(input logic v, input logic [8:0] w, input logic r, input logic n);
    logic rdy;
    in_valid = v;
    in_insn = w;
    out_ready = r;
    reset_n = n;
    @(posedge clk);
    rdy = (q.size() == 0) && !m_trap;
    if (!n) begin
      q.delete();
      m_trap = 0;
      m_op = 0;
      m_rd = 0;
      m_rs = 0;
    end else if (q.size() != 0 && r) void'(q.pop_front());
    else if (rdy && v) accept(w);
    @(negedge clk);
    rdy = (q.size() == 0) && !m_trap;
    check("in_ready", in_ready, rdy);
    check("busy", busy, !rdy);
    check("out_valid", out_valid, q.size() != 0);
    check("trap", trap, m_trap);
    check("out_op", out_op, q.size() != 0 ? q[0].op : m_op);
    check("out_rd", out_rd, q.size() != 0 ? q[0].rd : m_rd);
    check("out_rs", out_rs, q.size() != 0 ? q[0].rs : m_rs);
    check("out_last", out_last, q.size() != 0 ? q[0].last : 1'b0);
  endtask
  initial begin
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(1, 9'b000_010_011, 1, 1);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    tick(1, 9'b011_001_011, 1, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 1);
    tick(1, 9'b100_101_000, 1, 1);
    for (int i = 0; i < 9; i++) tick(0, 0, 1, 1);
    tick(1, 9'b011_110_010, 0, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 1);
    tick(1, 9'b111_011_101, 1, 1);
    for (int i = 0; i < 3; i++) tick(1, 9'b000_001_001, 1, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    tick(1, 9'b100_011_000, 1, 1);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 1);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(1, 0) == 1, 9'($urandom), $urandom_range(3, 0) != 0,
           !($urandom_range(99, 0) == 0 || (m_trap && $urandom_range(7, 0) == 0)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
